// File: rtl/smem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : smem_arbiter_if
// Brief    : Host, internal-port and SRAM-side signal bundle for smem_arbiter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface smem_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          i_smem_ext;
  logic          i_smem_cen;
  logic          i_smem_wen;
  logic [AW-1:0] i_smem_addr;
  logic [DW-1:0] i_smem_wdata;
  logic [DW-1:0] o_smem_rdata;

  logic          i_p0_req;
  logic          i_p0_we;
  logic [AW-1:0] i_p0_addr;
  logic [DW-1:0] i_p0_wdata;
  logic          o_p0_gnt;
  logic          o_p0_rvalid;
  logic [DW-1:0] o_p0_rdata;

  logic          i_p1_req;
  logic          i_p1_we;
  logic [AW-1:0] i_p1_addr;
  logic [DW-1:0] i_p1_wdata;
  logic          o_p1_gnt;
  logic          o_p1_rvalid;
  logic [DW-1:0] o_p1_rdata;

  logic          o_sram_cen;
  logic          o_sram_wen;
  logic [AW-1:0] o_sram_addr;
  logic [DW-1:0] o_sram_wdata;
  logic [DW-1:0] i_sram_rdata;

  modport slave (
    input  i_smem_ext, i_smem_cen, i_smem_wen, i_smem_addr, i_smem_wdata,
    output o_smem_rdata,
    input  i_p0_req, i_p0_we, i_p0_addr, i_p0_wdata,
    output o_p0_gnt, o_p0_rvalid, o_p0_rdata,
    input  i_p1_req, i_p1_we, i_p1_addr, i_p1_wdata,
    output o_p1_gnt, o_p1_rvalid, o_p1_rdata,
    output o_sram_cen, o_sram_wen, o_sram_addr, o_sram_wdata,
    input  i_sram_rdata
  );

  modport master (
    output i_smem_ext, i_smem_cen, i_smem_wen, i_smem_addr, i_smem_wdata,
    input  o_smem_rdata,
    output i_p0_req, i_p0_we, i_p0_addr, i_p0_wdata,
    input  o_p0_gnt, o_p0_rvalid, o_p0_rdata,
    output i_p1_req, i_p1_we, i_p1_addr, i_p1_wdata,
    input  o_p1_gnt, o_p1_rvalid, o_p1_rdata,
    input  o_sram_cen, o_sram_wen, o_sram_addr, o_sram_wdata,
    output i_sram_rdata
  );
endinterface

`default_nettype wire

// File: rtl/smem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : smem_arbiter
// Brief    : Single-port SRAM ownership switch between an external host and two
//            round-robin internal ports, with a one-cycle drain on handover.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module smem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  wire logic     i_clk,
  input  wire logic     i_reset,
  smem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_INT = 2'd0,
    S_SW  = 2'd1,
    S_EXT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  state_t        target_q, target_d;
  logic          ptr_q, ptr_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_port_q, rd_port_d;
  logic          host_rd_q, host_rd_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;
  logic [DW-1:0] smem_rdata_q, smem_rdata_d;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_rv0;
  logic          w_rv1;
  logic          w_cen;
  logic          w_wen;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  assign w_rv0 = rd_pend_q & ~rd_port_q;
  assign w_rv1 = rd_pend_q & rd_port_q;

  always_comb begin
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_cen        = 1'b1;
    w_wen        = 1'b1;
    w_addr       = '0;
    w_wdata      = '0;
    state_d      = state_q;
    target_d     = target_q;
    ptr_d        = ptr_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    smem_rdata_d = smem_rdata_q;

    // ptr_q holds the last granted port; on contention the other one wins.
    // Gating with i_reset keeps grants and SRAM strobes quiet while reset is held.
    if (state_q == S_INT && i_reset) begin
      w_gnt0 = bus.i_p0_req & (~bus.i_p1_req | ptr_q);
      w_gnt1 = bus.i_p1_req & (~bus.i_p0_req | ~ptr_q);
    end

    if (w_gnt0) begin
      w_cen   = 1'b0;
      w_wen   = ~bus.i_p0_we;
      w_addr  = bus.i_p0_addr;
      w_wdata = bus.i_p0_wdata;
    end else if (w_gnt1) begin
      w_cen   = 1'b0;
      w_wen   = ~bus.i_p1_we;
      w_addr  = bus.i_p1_addr;
      w_wdata = bus.i_p1_wdata;
    end else if (state_q == S_EXT && i_reset) begin
      w_cen   = bus.i_smem_cen;
      w_wen   = bus.i_smem_wen;
      w_addr  = bus.i_smem_addr;
      w_wdata = bus.i_smem_wdata;
    end

    if (w_gnt0 | w_gnt1) ptr_d = w_gnt1;
    rd_pend_d = (w_gnt0 & ~bus.i_p0_we) | (w_gnt1 & ~bus.i_p1_we);
    rd_port_d = w_gnt1;
    host_rd_d = (state_q == S_EXT) & ~bus.i_smem_cen & bus.i_smem_wen;

    if (w_rv0)     p0_rdata_d   = bus.i_sram_rdata;
    if (w_rv1)     p1_rdata_d   = bus.i_sram_rdata;
    if (host_rd_q) smem_rdata_d = bus.i_sram_rdata;

    case (state_q)
      S_INT: if (bus.i_smem_ext) begin
        state_d  = S_SW;
        target_d = S_EXT;
      end
      S_EXT: if (!bus.i_smem_ext) begin
        state_d  = S_SW;
        target_d = S_INT;
      end
      S_SW:    state_d = target_q;
      default: state_d = S_INT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= S_INT;
      target_q     <= S_INT;
      ptr_q        <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_port_q    <= 1'b0;
      host_rd_q    <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      smem_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      ptr_q        <= ptr_d;
      rd_pend_q    <= rd_pend_d;
      rd_port_q    <= rd_port_d;
      host_rd_q    <= host_rd_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      smem_rdata_q <= smem_rdata_d;
    end
  end

  assign bus.o_p0_gnt     = w_gnt0;
  assign bus.o_p1_gnt     = w_gnt1;
  assign bus.o_p0_rvalid  = w_rv0;
  assign bus.o_p1_rvalid  = w_rv1;
  assign bus.o_p0_rdata   = w_rv0 ? bus.i_sram_rdata : p0_rdata_q;
  assign bus.o_p1_rdata   = w_rv1 ? bus.i_sram_rdata : p1_rdata_q;
  assign bus.o_smem_rdata = host_rd_q ? bus.i_sram_rdata : smem_rdata_q;
  assign bus.o_sram_cen   = w_cen;
  assign bus.o_sram_wen   = w_wen;
  assign bus.o_sram_addr  = w_addr;
  assign bus.o_sram_wdata = w_wdata;

endmodule

`default_nettype wire
